// File: rtl/uart_tx_mmio_if.sv
// Data-memory port bundle between the CPU EX stage and the UART transmitter.
interface uart_tx_mmio_if;
    logic        mem_ena;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (output mem_ena, mem_rw, mem_addr, mem_wdata, input mem_rdata);
    modport slave  (input mem_ena, mem_rw, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: DATA/STATUS registers, transmit FIFO, 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frame).
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          CLK_DIV    = 868,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_mmio_if.slave bus,
    output logic          tx
);
    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam int          CW         = AW + 1;
    localparam logic [15:0] BIT_RELOAD = 16'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state, state_nx;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [7:0]    shreg;
    logic [15:0]   bit_cnt, bit_cnt_nx;
    logic [2:0]    bit_idx, bit_idx_nx;
    logic          tx_nx, overflow, pop, load, shift, bit_done;
    logic          hit_data, hit_status, wr_en, push, full, empty, busy;
    logic          unused_wdata;
`ifdef UART_TX_PARITY_EN
    logic          parity;
`endif

    assign hit_data     = bus.mem_addr == BASE_ADDR;
    assign hit_status   = bus.mem_addr == BASE_ADDR + 32'd4;
    assign wr_en        = bus.mem_ena & bus.mem_rw;
    assign full         = count == CW'(FIFO_DEPTH);
    assign empty        = count == '0;
    assign busy         = state != IDLE;
    assign push         = wr_en & hit_data & ~full;
    assign bit_done     = bit_cnt == '0;
    assign unused_wdata = ^bus.mem_wdata[31:8];

    assign bus.mem_rdata = (bus.mem_ena && !bus.mem_rw && hit_status) ?
                           {28'b0, overflow, busy, empty, full} : 32'b0;

    // Fullness is sampled before this edge's pop, so a write to a full FIFO is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
            if (wr_en && hit_status)          overflow <= 1'b0;
            else if (wr_en && hit_data && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.mem_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (load) begin
            shreg <= fifo_mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
            parity <= ^fifo_mem[rd_ptr];
`endif
        end else if (shift) begin
            shreg <= {1'b0, shreg[7:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_cnt_nx;
            bit_idx <= bit_idx_nx;
            tx      <= tx_nx;
        end
    end

    // tx_nx is the value the line takes for the whole of the next bit.
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_done ? BIT_RELOAD : bit_cnt - 16'd1;
        bit_idx_nx = bit_idx;
        tx_nx      = tx;
        pop        = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        case (state)
            IDLE: begin
                bit_cnt_nx = '0;
                if (!empty) begin
                    pop        = 1'b1;
                    load       = 1'b1;
                    state_nx   = START;
                    tx_nx      = 1'b0;
                    bit_cnt_nx = BIT_RELOAD;
                end
            end
            START: begin
                if (bit_done) begin
                    state_nx   = DATA;
                    bit_idx_nx = '0;
                    tx_nx      = shreg[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx == 3'd7) begin
                        bit_idx_nx = '0;
`ifdef UART_TX_PARITY_EN
                        state_nx = PARITY;
                        tx_nx    = parity;
`else
                        state_nx = STOP;
                        tx_nx    = 1'b1;
`endif
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                        shift      = 1'b1;
                        tx_nx      = shreg[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_nx = STOP;
                    tx_nx    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    if (!empty) begin
                        pop      = 1'b1;
                        load     = 1'b1;
                        state_nx = START;
                        tx_nx    = 1'b0;
                    end else begin
                        state_nx   = IDLE;
                        bit_cnt_nx = '0;
                    end
                end
            end
            default: begin
                state_nx   = IDLE;
                bit_cnt_nx = '0;
                tx_nx      = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with CLK_DIV=4, FIFO_DEPTH=4.
module tb_uart_tx_mmio;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tx;
    int   checks = 0;
    int   errors = 0;

    uart_tx_mmio_if bus();

    uart_tx_mmio #(.BASE_ADDR(BASE), .CLK_DIV(DIV), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .tx (tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ena;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_tx;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.mem_ena   = 1'b0;
        bus.mem_rw    = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus.mem_ena   = 1'b1;
        bus.mem_rw    = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = data;
        tick();
        bus_idle();
    endtask

    task automatic read_status(output logic [31:0] v);
        bus.mem_ena  = 1'b1;
        bus.mem_rw   = 1'b0;
        bus.mem_addr = BASE + 32'd4;
        #1;
        v = bus.mem_rdata;
        bus_idle();
    endtask

    task automatic check_status(input string name, input logic [31:0] exp);
        logic [31:0] st;
        read_status(st);
        check(name, st, exp);
    endtask

    // Starts at frame cycle 'skip' (cycle 0 = first start-bit cycle) and ends one cycle past stop.
    task automatic check_frame(input logic [7:0] b, input int skip, input logic exp_empty);
        logic [10:0] fr;
        logic [31:0] st;
        fr      = '1;
        fr[0]   = 1'b0;
        fr[8:1] = b;
`ifdef UART_TX_PARITY_EN
        fr[9]   = ^b;
`endif
        for (int c = skip; c < NB * DIV; c++) begin
            if (c == skip) begin
                read_status(st);
                check($sformatf("busy@start %h", b), 32'(st[2]), 32'd1);
                check($sformatf("empty@start %h", b), 32'(st[1]), 32'(exp_empty));
            end
            if (c == NB * DIV - 1) begin
                read_status(st);
                check($sformatf("busy@lastcycle %h", b), 32'(st[2]), 32'd1);
            end
            check($sformatf("tx %h cyc%0d", b, c), 32'(tx), 32'(fr[c / DIV]));
            tick();
        end
    endtask

    task automatic check_line_idle(input string name, input int ncyc);
        int bad;
        bad = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (tx !== 1'b1) bad++;
            tick();
        end
        check(name, 32'(bad), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b0, BASE + 32'd4,  32'h0,  32'h2, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, BASE,          32'h0,  32'h0, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, BASE + 32'd8,  32'h0,  32'h0, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, BASE + 32'd8,  32'hFF, 32'h0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, BASE + 32'd4,  32'h0,  32'h2, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, BASE + 32'd8,  32'h0,  32'h0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, BASE + 32'd4,  32'h0,  32'h0, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, BASE + 32'd12, 32'hAA, 32'h0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, BASE + 32'd5,  32'h0,  32'h0, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, BASE + 32'd4,  32'h0,  32'h0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, BASE + 32'd4,  32'h0,  32'h2, 1'b1};
        vecs[11] = '{1'b1, 1'b0, BASE + 32'd1,  32'h0,  32'h0, 1'b1};
        vecs[12] = '{1'b1, 1'b0, BASE + 32'd4,  32'h0,  32'h2, 1'b1};

        bus_idle();
        rst = 1'b0;
        tick();
        tick();
        check("tx in reset", 32'(tx), 32'd1);
        check_status("status in reset", 32'h2);
        rst = 1'b1;
        tick();

        // Register map, unmapped addresses and read-port gating
        for (int i = 0; i < NV; i++) begin
            bus.mem_ena   = vecs[i].ena;
            bus.mem_rw    = vecs[i].rw;
            bus.mem_addr  = vecs[i].addr;
            bus.mem_wdata = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d rdata", i), bus.mem_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d tx", i), 32'(tx), 32'(vecs[i].exp_tx));
            tick();
            bus_idle();
        end

        // Reset during data bit 3 aborts the frame and discards the queued byte
        bus_write(BASE, 32'h52);
        bus_write(BASE, 32'h77);
        repeat (4 * DIV + 1) tick();
        check("tx bit3 before reset", 32'(tx), 32'd0);
        rst = 1'b0;
        #1;
        check("tx async reset", 32'(tx), 32'd1);
        check_status("status during reset", 32'h2);
        tick();
        tick();
        rst = 1'b1;
        check_status("status after reset", 32'h2);

        // First write after release; single 0x55 frame
        bus_write(BASE, 32'h55);
        check_status("status queued", 32'h0);
        tick();
        check_frame(8'h55, 0, 1'b1);
        check_status("status after 55", 32'h2);
        check_line_idle("idle after reset abort", 30);

        // Back-to-back frames with no gap
        bus_write(BASE, 32'hA5);
        bus_write(BASE, 32'h3C);
        check_frame(8'hA5, 0, 1'b0);
        check_frame(8'h3C, 0, 1'b1);
        check_status("status after 3C", 32'h2);

        // Overflow: five writes into a 4-deep FIFO while busy
        bus_write(BASE, 32'h11);
        bus_write(BASE, 32'h21);
        bus_write(BASE, 32'h32);
        bus_write(BASE, 32'h43);
        bus_write(BASE, 32'h54);
        bus_write(BASE, 32'h65);
        check_status("status overflow", 32'hD);
        bus_write(BASE + 32'd4, 32'hFFFF_FFFF);
        check_status("status ovf cleared", 32'h5);
        check_frame(8'h11, 5, 1'b0);
        check_frame(8'h21, 0, 1'b0);
        check_frame(8'h32, 0, 1'b0);
        check_frame(8'h43, 0, 1'b0);
        check_frame(8'h54, 0, 1'b1);
        check_status("status after burst", 32'h2);
        check_line_idle("dropped byte not sent", 60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_mmio.md
UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1000_0000, base of the 8-byte register window.
REQ-002 Parameter CLK_DIV, default 868, clock cycles per serial bit; legal range 2..65535.
REQ-003 Parameter FIFO_DEPTH, default 8, transmit FIFO entries; power of two, 2..64.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 mem_ena  in  1  data-memory access valid this cycle.
REQ-007 mem_rw  in  1  0 read, 1 write.
REQ-008 mem_addr  in  32  byte address from the EX-stage data port.
REQ-009 mem_wdata  in  32  write data; only bits [7:0] used.
REQ-010 mem_rdata  out  32  combinational read data, valid in the same cycle as the address.
REQ-011 tx  out  1  serial line, idle high.

Function
REQ-012 The block SHALL map DATA at BASE_ADDR+0 and STATUS at BASE_ADDR+4; other addresses SHALL return 0 and ignore writes.
REQ-013 A write (mem_ena=1, mem_rw=1) to DATA while the FIFO is not full SHALL push mem_wdata[7:0] at that rising edge.
REQ-014 A write to DATA while the FIFO is full SHALL be dropped and set the sticky overflow bit; fullness is evaluated before any same-edge pop.
REQ-015 A write to STATUS SHALL clear overflow; its data is ignored.
REQ-016 STATUS read SHALL return {28'b0, overflow, busy, empty, full}; DATA read SHALL return 0.
REQ-017 mem_rdata SHALL be purely combinational from mem_addr, mem_ena and current state; mem_ena=0 or mem_rw=1 returns 0.
REQ-018 Reads SHALL have no side effects.
REQ-019 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; busy=1 in all states except IDLE.
REQ-020 IDLE with FIFO non-empty SHALL pop one byte at the next edge and enter START; tx=0 from that edge.
REQ-021 Each bit SHALL last exactly CLK_DIV cycles, timed by a down-counter reloaded with CLK_DIV-1 on every state/bit change.
REQ-022 DATA SHALL shift 8 bits LSB first, tracked by a 3-bit index, then go to PARITY (if enabled) or STOP.
REQ-023 STOP SHALL drive tx=1 for one bit time, then pop the next byte directly into START if the FIFO is non-empty, otherwise enter IDLE (no extra idle cycle between back-to-back frames).
REQ-024 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be log2(FIFO_DEPTH)+1 bits; full when count==FIFO_DEPTH, empty when count==0.
REQ-025 Simultaneous push and pop with FIFO not full SHALL leave count unchanged and both succeed.
REQ-026 tx SHALL be driven from a register (glitch-free).

Reset
REQ-027 Asserting rst SHALL immediately, without clock, set tx=1, state=IDLE, FIFO empty (pointers and count 0), overflow=0, bit counter and index 0.
REQ-028 Reset mid-frame SHALL abort the frame; queued bytes are discarded.
REQ-029 After release, the first DATA write SHALL be accepted on the first rising edge.

Configuration
REQ-030 Macro UART_TX_PARITY_EN defined: PARITY state SHALL transmit even parity (XOR of the 8 data bits) for one bit time; frame = 11 bits.
REQ-031 Macro UART_TX_PARITY_EN undefined: PARITY state SHALL not exist or be reachable; frame = 10 bits (8N1).

Verification (bench uses CLK_DIV=4, FIFO_DEPTH=4)
REQ-032 Reset, write 8'h55 to DATA -> tx low 4 cycles from the next edge, then 1,0,1,0,1,0,1,0 each 4 cycles, high 4 cycles; busy falls after 40 cycles (44 with parity, parity bit 0).
REQ-033 Write 8'hA5 then 8'h3C in consecutive cycles -> two contiguous frames, second start bit immediately after first stop bit, empty=1 during second frame.
REQ-034 While busy, write 5 bytes to a 4-deep FIFO -> STATUS reads 32'h0000_000D (overflow, busy, full); STATUS write clears bit 3; fifth byte never transmitted.
REQ-035 Assert rst during DATA bit 3 of a frame -> tx=1 same cycle, STATUS after release reads 32'h0000_0002.
REQ-036 Read BASE_ADDR+8 and write 8'hFF there -> mem_rdata 0, FIFO unchanged, tx stays high.
